// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// One operand bit is processed per cycle: shift-add multiply, restoring divide.
module mult_div_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    input  logic             mthi,
    input  logic             mtlo,
    input  logic [WIDTH-1:0] wdata,
    input  logic             rd_hilo,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             stall,
    output logic             dz
);

    localparam int unsigned CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [CW-1:0]      cnt;
    logic [1:0]         op_q;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic [WIDTH-1:0]   acc_hi;
    logic [WIDTH-1:0]   acc_lo;

    logic               accept;
    logic               last;
    logic               is_div;
    logic               a_neg;
    logic               b_neg;
    logic               div0;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [WIDTH-1:0]   ld_src;
    logic [WIDTH-1:0]   ld_mag;
    logic [WIDTH:0]     msum;
    logic [WIDTH:0]     trial;
    logic [WIDTH-1:0]   nxt_hi;
    logic [WIDTH-1:0]   nxt_lo;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   res_hi;
    logic [WIDTH-1:0]   res_lo;

    assign accept = start && !flush;
    assign last   = (cnt == CW'(WIDTH - 1));

    // Operand magnitudes, one iteration step and the sign-corrected final result
    always_comb begin
        is_div = op_q[1];
        a_neg  = !op_q[0] && a_q[WIDTH-1];
        b_neg  = !op_q[0] && b_q[WIDTH-1];
        a_mag  = a_neg ? WIDTH'(-a_q) : a_q;
        b_mag  = b_neg ? WIDTH'(-b_q) : b_q;
        div0   = (b_q == '0);

        // multiplier (mult) or dividend (div) magnitude loaded into acc_lo at start
        ld_src = op[1] ? a : b;
        ld_mag = (!op[0] && ld_src[WIDTH-1]) ? WIDTH'(-ld_src) : ld_src;

        msum  = {1'b0, acc_hi} + {1'b0, (acc_lo[0] ? a_mag : '0)};
        trial = {acc_hi, acc_lo[WIDTH-1]} - {1'b0, b_mag};

        if (is_div) begin
            nxt_hi = trial[WIDTH] ? {acc_hi[WIDTH-2:0], acc_lo[WIDTH-1]} : trial[WIDTH-1:0];
            nxt_lo = {acc_lo[WIDTH-2:0], !trial[WIDTH]};
        end else begin
            nxt_hi = msum[WIDTH:1];
            nxt_lo = {msum[0], acc_lo[WIDTH-1:1]};
        end

        prod = {nxt_hi, nxt_lo};
        if (a_neg ^ b_neg) begin
            prod = (2*WIDTH)'(-prod);
        end

        if (!is_div) begin
            res_hi = prod[2*WIDTH-1:WIDTH];
            res_lo = prod[WIDTH-1:0];
        end else if (div0) begin
            res_hi = a_q;
            res_lo = '1;
        end else begin
            res_hi = a_neg ? WIDTH'(-nxt_hi) : nxt_hi;
            res_lo = (a_neg ^ b_neg) ? WIDTH'(-nxt_lo) : nxt_lo;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = RUN;
            RUN:     if (flush) state_nxt = IDLE;
                     else if (last) state_nxt = FIN;
            FIN:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Moore status outputs and hazard stall request
    always_comb begin
        busy  = (state == RUN);
        done  = (state == FIN);
        stall = rst && (state != IDLE) && (start || rd_hilo || mthi || mtlo);
    end

    // Operand capture, iteration datapath and HI/LO/dz update
    always_ff @(posedge clk) begin
        if (!rst) begin
            hi     <= '0;
            lo     <= '0;
            dz     <= 1'b0;
            cnt    <= '0;
            op_q   <= '0;
            a_q    <= '0;
            b_q    <= '0;
            acc_hi <= '0;
            acc_lo <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        op_q   <= op;
                        a_q    <= a;
                        b_q    <= b;
                        dz     <= 1'b0;
                        cnt    <= '0;
                        acc_hi <= '0;
                        acc_lo <= ld_mag;
                    end else begin
                        if (mthi) hi <= wdata;
                        if (mtlo) lo <= wdata;
                    end
                end
                RUN: begin
                    if (!flush) begin
                        acc_hi <= nxt_hi;
                        acc_lo <= nxt_lo;
                        cnt    <= cnt + CW'(1);
                        if (last) begin
                            hi <= res_hi;
                            lo <= res_lo;
                            dz <= is_div && div0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit at WIDTH=32 with hand-computed results.
module tb_mult_div_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        flush;
    logic        mthi;
    logic        mtlo;
    logic [31:0] wdata;
    logic        rd_hilo;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        done;
    logic        stall;
    logic        dz;

    int total = 0;
    int bad   = 0;

    mult_div_unit #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
        .flush(flush), .mthi(mthi), .mtlo(mtlo), .wdata(wdata),
        .rd_hilo(rd_hilo), .hi(hi), .lo(lo), .busy(busy), .done(done),
        .stall(stall), .dz(dz)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called in cycle 1 after the start edge; returns in the done cycle (or at timeout)
    task automatic wait_done(output int cyc, output int bcnt);
        cyc  = 1;
        bcnt = 0;
        while (done !== 1'b1 && cyc < 60) begin
            if (busy === 1'b1) bcnt++;
            tick();
            cyc++;
        end
    endtask

    task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                          output int cyc, output int bcnt);
        op = o; a = x; b = y; start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(cyc, bcnt);
    endtask

    initial begin
        int cyc;
        int bcnt;
        int stall_low;
        int lo_moved;
        bit saw_done;

        rst = 1'b0; start = 1'b1; op = 2'b00; a = 32'd5; b = 32'd6;
        flush = 1'b0; mthi = 1'b1; mtlo = 1'b1; wdata = 32'hFFFF_0000; rd_hilo = 1'b1;
        repeat (3) tick();
        chk("reset_hi", 64'(hi), 64'h0);
        chk("reset_lo", 64'(lo), 64'h0);
        chk("reset_busy", 64'(busy), 64'h0);
        chk("reset_done", 64'(done), 64'h0);
        chk("reset_dz", 64'(dz), 64'h0);
        chk("reset_stall", 64'(stall), 64'h0);

        rst = 1'b1; start = 1'b0; rd_hilo = 1'b0; mthi = 1'b0; mtlo = 1'b0;
        tick();

        // mthi + mtlo together in IDLE write both
        mthi = 1'b1; mtlo = 1'b1; wdata = 32'hA5A5_A5A5;
        tick();
        mthi = 1'b0; mtlo = 1'b0;
        chk("mthi_mtlo_hi", 64'(hi), 64'hA5A5_A5A5);
        chk("mthi_mtlo_lo", 64'(lo), 64'hA5A5_A5A5);

        // MULT -3*7 with a simultaneous mthi that must be discarded
        op = 2'b00; a = 32'hFFFF_FFFD; b = 32'd7; start = 1'b1;
        mthi = 1'b1; wdata = 32'hDEAD_BEEF;
        tick();
        start = 1'b0; mthi = 1'b0;
        chk("start_mthi_discard", 64'(hi), 64'hA5A5_A5A5);
        chk("mult_busy_c1", 64'(busy), 64'h1);
        wait_done(cyc, bcnt);
        chk("mult_done_cycle", 64'(cyc), 64'd33);
        chk("mult_hi", 64'(hi), 64'hFFFF_FFFF);
        chk("mult_lo", 64'(lo), 64'hFFFF_FFEB);
        chk("mult_busy_in_fin", 64'(busy), 64'h0);
        tick();
        chk("done_one_cycle", 64'(done), 64'h0);

        run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, cyc, bcnt);
        chk("multu_busy_cycles", 64'(bcnt), 64'd32);
        chk("multu_hi", 64'(hi), 64'hFFFF_FFFE);
        chk("multu_lo", 64'(lo), 64'h0000_0001);
        tick();

        run_op(2'b00, 32'hFFFF_FFFB, 32'hFFFF_FFFA, cyc, bcnt);
        chk("mult_negneg_hi", 64'(hi), 64'h0);
        chk("mult_negneg_lo", 64'(lo), 64'd30);
        tick();

        run_op(2'b10, 32'hFFFF_FFF9, 32'd2, cyc, bcnt);
        chk("div_neg7_2_lo", 64'(lo), 64'hFFFF_FFFD);
        chk("div_neg7_2_hi", 64'(hi), 64'hFFFF_FFFF);
        chk("div_neg7_2_dz", 64'(dz), 64'h0);
        tick();

        run_op(2'b10, 32'd7, 32'hFFFF_FFFE, cyc, bcnt);
        chk("div_7_neg2_lo", 64'(lo), 64'hFFFF_FFFD);
        chk("div_7_neg2_hi", 64'(hi), 64'h1);
        tick();

        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, cyc, bcnt);
        chk("div_ovf_lo", 64'(lo), 64'h8000_0000);
        chk("div_ovf_hi", 64'(hi), 64'h0);
        chk("div_ovf_dz", 64'(dz), 64'h0);
        tick();

        run_op(2'b11, 32'h0000_1234, 32'h0, cyc, bcnt);
        chk("divu_zero_lo", 64'(lo), 64'hFFFF_FFFF);
        chk("divu_zero_hi", 64'(hi), 64'h0000_1234);
        chk("divu_zero_dz", 64'(dz), 64'h1);
        tick();
        chk("dz_holds_idle", 64'(dz), 64'h1);

        op = 2'b11; a = 32'd100; b = 32'd7; start = 1'b1;
        tick();
        start = 1'b0;
        chk("dz_cleared_by_start", 64'(dz), 64'h0);
        wait_done(cyc, bcnt);
        chk("divu_100_7_lo", 64'(lo), 64'd14);
        chk("divu_100_7_hi", 64'(hi), 64'd2);
        tick();

        // rd_hilo held through RUN/FIN; mtlo during RUN is ignored
        op = 2'b01; a = 32'd9; b = 32'd9; start = 1'b1;
        tick();
        start = 1'b0; rd_hilo = 1'b1; mtlo = 1'b1; wdata = 32'h5555_5555;
        stall_low = 0; lo_moved = 0; cyc = 1;
        while (done !== 1'b1 && cyc < 60) begin
            if (stall !== 1'b1) stall_low++;
            if (lo !== 32'd14) lo_moved++;
            tick();
            cyc++;
        end
        mtlo = 1'b0;
        if (stall !== 1'b1) stall_low++;
        chk("stall_run_fin", 64'(stall_low), 64'd0);
        chk("mtlo_in_run_ignored", 64'(lo_moved), 64'd0);
        chk("mulu_9_9_lo", 64'(lo), 64'd81);
        tick();
        chk("stall_idle_after", 64'(stall), 64'h0);
        rd_hilo = 1'b0;

        // flush at RUN cycle 10
        mthi = 1'b1; mtlo = 1'b1; wdata = 32'h1111_1111;
        tick();
        mthi = 1'b0; wdata = 32'h2222_2222;
        tick();
        mtlo = 1'b0;
        op = 2'b01; a = 32'd3; b = 32'd3; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (9) tick();
        chk("flush_busy_before", 64'(busy), 64'h1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_busy_after", 64'(busy), 64'h0);
        saw_done = 1'b0;
        repeat (40) begin
            if (done === 1'b1) saw_done = 1'b1;
            tick();
        end
        chk("flush_no_done", 64'(saw_done), 64'h0);
        chk("flush_hi_kept", 64'(hi), 64'h1111_1111);
        chk("flush_lo_kept", 64'(lo), 64'h2222_2222);

        // synchronous reset mid-RUN overrides everything
        op = 2'b00; a = 32'd12; b = 32'd12; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (5) tick();
        rst = 1'b0; start = 1'b1; rd_hilo = 1'b1; mthi = 1'b1;
        tick();
        chk("midrun_rst_hi", 64'(hi), 64'h0);
        chk("midrun_rst_lo", 64'(lo), 64'h0);
        chk("midrun_rst_busy", 64'(busy), 64'h0);
        chk("midrun_rst_done", 64'(done), 64'h0);
        chk("midrun_rst_dz", 64'(dz), 64'h0);
        chk("midrun_rst_stall", 64'(stall), 64'h0);
        rst = 1'b1; start = 1'b0; rd_hilo = 1'b0; mthi = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 Parameter WIDTH, default 32, operand and HI/LO width in bits, legal values 8..64, even.
REQ-002 Port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 Port rst  input  1  reset, synchronous, active-low.
REQ-004 Port start  input  1  operation request from execute stage, sampled each rising edge.
REQ-005 Port op  input  2  operation: 00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU.
REQ-006 Port a, b  input  WIDTH  operands; a is multiplicand/dividend, b is multiplier/divisor.
REQ-007 Port flush  input  1  branch-flush kill of in-flight operation.
REQ-008 Port mthi, mtlo  input  1  direct write of wdata into HI or LO.
REQ-009 Port wdata  input  WIDTH  data for mthi/mtlo.
REQ-010 Port rd_hilo  input  1  decode stage holds an MFHI/MFLO needing the result.
REQ-011 Port hi, lo  output  WIDTH  architectural HI and LO registers.
REQ-012 Port busy  output  1  high in RUN state.
REQ-013 Port done  output  1  one-cycle pulse when HI/LO take a new result.
REQ-014 Port stall  output  1  pipeline stall request to hazard unit.
REQ-015 Port dz  output  1  divide-by-zero flag for the last completed division.

Function
REQ-016 State machine SHALL have states IDLE, RUN, FIN; a counter of ceil(log2(WIDTH))+1 bits tracks RUN iterations.
REQ-017 IDLE: start=1 and flush=0 SHALL latch op, a, b, clear dz, zero counter, go to RUN; otherwise stay IDLE.
REQ-018 RUN SHALL process exactly one operand bit per cycle (shift-add multiply, restoring divide) for WIDTH cycles, then go to FIN.
REQ-019 Signed ops SHALL operate on magnitudes and apply sign correction at completion; unsigned ops use operands unchanged.
REQ-020 On the RUN->FIN edge HI/LO SHALL load the result: multiply {HI,LO}=2*WIDTH-bit product; divide LO=quotient, HI=remainder.
REQ-021 Signed divide remainder SHALL carry the sign of the dividend; quotient truncates toward zero.
REQ-022 Divisor zero SHALL yield LO=all ones, HI=dividend, dz=1; dz holds until next accepted start or reset.
REQ-023 Signed most-negative / -1 SHALL yield LO=most-negative value, HI=0, dz=0.
REQ-024 FIN SHALL last one cycle with done=1, then go to IDLE; start in FIN is ignored (stall covers it).
REQ-025 Latency: start accepted at edge N -> busy high cycles N+1..N+WIDTH, done high cycle N+WIDTH+1, HI/LO valid from that cycle.
REQ-026 stall SHALL equal (busy or FIN) and (start or rd_hilo or mthi or mtlo), combinationally.
REQ-027 mthi/mtlo SHALL write HI/LO only in IDLE; while busy or in FIN they are ignored (and stalled per REQ-026).
REQ-028 mthi and mtlo in same IDLE cycle SHALL write both; mthi/mtlo together with start in IDLE: start accepted, writes discarded.
REQ-029 flush=1 in RUN SHALL return to IDLE next edge with HI/LO and dz unchanged and no done pulse.
REQ-030 flush in FIN SHALL have no effect; the result commits.

Reset
REQ-031 rst=0 at a rising edge SHALL force IDLE, counter 0, hi=0, lo=0, busy=0, done=0, dz=0, overriding all other inputs, including mid-RUN.
REQ-032 stall SHALL be 0 while in reset state regardless of inputs.

Verification (WIDTH=32)
REQ-033 MULT a=0xFFFFFFFD (-3), b=7 -> done at cycle 33 after start, HI=0xFFFFFFFF, LO=0xFFFFFFEB.
REQ-034 MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001; busy exactly 32 cycles.
REQ-035 DIV a=0xFFFFFFF9 (-7), b=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0, dz=0.
REQ-036 DIVU a=0x1234, b=0 -> LO=0xFFFFFFFF, HI=0x1234, dz=1; next start clears dz.
REQ-037 rd_hilo held during RUN -> stall=1 every busy cycle and FIN, 0 in following IDLE; mtlo during RUN leaves LO unchanged.
REQ-038 flush at RUN cycle 10, then rst=0 mid-RUN of a second op -> first: HI/LO keep prior values, no done; second: all outputs 0 next edge.
